// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame-buffer write buffer:
// APB response values, parameter defaults and the buffered-write entry.
package vga_pkg;

  localparam int VGA_DEPTH_DEF  = 8;
  localparam int VGA_FB_AW_DEF  = 21;
  localparam int VGA_FB_AW_MAX  = 30;

  localparam logic [31:0] APB_RDATA_NONE = 32'h0000_0000;
  localparam logic        APB_RESP_OKAY  = 1'b0;
  localparam logic        APB_RESP_ERR   = 1'b1;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_phase_e;

  // The full word address is kept; the top slices it down to FB_AW bits.
  typedef struct packed {
    logic [VGA_FB_AW_MAX-1:0] addr;
    logic [31:0]              data;
    logic [3:0]               strb;
  } wbuf_entry_t;

  function automatic apb_phase_e apb_phase(input logic psel, input logic penable);
    apb_phase_e ph;
    case ({psel, penable})
      2'b10:   ph = APB_SETUP;
      2'b11:   ph = APB_ACCESS;
      default: ph = APB_IDLE;
    endcase
    return ph;
  endfunction

  function automatic wbuf_entry_t wbuf_make_entry(input logic [31:0] paddr,
                                                  input logic [31:0] pwdata,
                                                  input logic [3:0]  pstrb);
    wbuf_entry_t e;
    e.addr = paddr[31:2];
    e.data = pwdata;
    e.strb = pstrb;
    return e;
  endfunction

endpackage

// File: rtl/vga_fb_wbuf_if.sv
// APB slave and frame-buffer write port bundle for vga_fb_wbuf.
interface vga_fb_wbuf_if import vga_pkg::*; #(
  parameter int FB_AW = VGA_FB_AW_DEF
) ();

  logic [31:0]      in_paddr;
  logic             in_psel;
  logic             in_penable;
  logic [2:0]       in_pprot;
  logic             in_pwrite;
  logic [31:0]      in_pwdata;
  logic [3:0]       in_pstrb;
  logic             in_pready;
  logic [31:0]      in_prdata;
  logic             in_pslverr;

  logic             fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [31:0]      fb_wdata;
  logic [3:0]       fb_wstrb;
  logic             fb_ready;
  logic             vga_blank;

  modport slave (
    input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    input  fb_ready, vga_blank,
    output in_pready, in_prdata, in_pslverr,
    output fb_we, fb_addr, fb_wdata, fb_wstrb
  );

  modport master (
    output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    output fb_ready, vga_blank,
    input  in_pready, in_prdata, in_pslverr,
    input  fb_we, fb_addr, fb_wdata, fb_wstrb
  );

endinterface

// File: rtl/vga_wbuf_fifo.sv
// Synchronous write FIFO; full is judged on current occupancy only, so a
// simultaneous pop never lets a push into a full buffer.
module vga_wbuf_fifo import vga_pkg::*; #(
  parameter int DEPTH = VGA_DEPTH_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  wbuf_entry_t push_entry,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output wbuf_entry_t head,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1):0] count
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  wbuf_entry_t      mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; stale contents are unreachable once the counter is cleared.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

endmodule

// File: rtl/vga_fb_wbuf.sv
// Posted APB write buffer in front of the frame buffer. Reads are rejected
// with an error response. Define VGA_WBUF_BLANK_ONLY_EN to drain only while
// vga_blank is high.
module vga_fb_wbuf import vga_pkg::*; #(
  parameter int DEPTH = VGA_DEPTH_DEF,
  parameter int FB_AW = VGA_FB_AW_DEF
) (
  input logic           clock,
  input logic           reset,
  vga_fb_wbuf_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_phase_e   phase_s;
  wbuf_entry_t  push_entry_s;
  wbuf_entry_t  head_s;
  logic         push_s;
  logic         pop_s;
  logic         full_s;
  logic         empty_s;
  logic         drain_en_s;
  logic         fb_we_s;
  logic         pready_s;
  logic         pslverr_s;
  logic [AW:0]  count_s;
  logic         unused_s;

  assign phase_s      = apb_phase(bus.in_psel, bus.in_penable);
  assign push_entry_s = wbuf_make_entry(bus.in_paddr, bus.in_pwdata, bus.in_pstrb);

  // APB access decode: writes wait while full, reads finish at once with an error.
  always_comb begin
    pready_s  = 1'b0;
    pslverr_s = APB_RESP_OKAY;
    push_s    = 1'b0;
    if (phase_s == APB_ACCESS) begin
      if (bus.in_pwrite) begin
        pready_s  = ~full_s;
        push_s    = ~full_s;
        pslverr_s = APB_RESP_OKAY;
      end else begin
        pready_s  = 1'b1;
        push_s    = 1'b0;
        pslverr_s = APB_RESP_ERR;
      end
    end else begin
      pready_s  = 1'b0;
      pslverr_s = APB_RESP_OKAY;
      push_s    = 1'b0;
    end
  end

  assign bus.in_pready  = pready_s;
  assign bus.in_prdata  = APB_RDATA_NONE;
  assign bus.in_pslverr = pslverr_s;

`ifdef VGA_WBUF_BLANK_ONLY_EN
  assign drain_en_s = bus.vga_blank;
  assign unused_s   = ^{bus.in_paddr[1:0], bus.in_pprot, head_s.addr, count_s};
`else
  assign drain_en_s = 1'b1;
  assign unused_s   = ^{bus.in_paddr[1:0], bus.in_pprot, head_s.addr, count_s, bus.vga_blank};
`endif

  assign fb_we_s      = ~empty_s & drain_en_s;
  assign pop_s        = fb_we_s & bus.fb_ready;

  assign bus.fb_we    = fb_we_s;
  assign bus.fb_addr  = head_s.addr[FB_AW-1:0];
  assign bus.fb_wdata = head_s.data;
  assign bus.fb_wstrb = head_s.strb;

  vga_wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .full       (full_s),
    .empty      (empty_s),
    .head       (head_s),
    .count      (count_s)
  );

endmodule

// File: tb/tb_vga_fb_wbuf.sv
// Directed/randomized bench for vga_fb_wbuf against a queue-based model.
module tb_vga_fb_wbuf;

  localparam int DEPTH = 8;
  localparam int FB_AW = 21;

  typedef struct {
    logic [FB_AW-1:0] addr;
    logic [31:0]      data;
    logic [3:0]       strb;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  exp_t        q[$];
  logic [31:0] dut_log[$];
  bit          rand_ready = 1'b0;

  logic             obs_pready, obs_pslverr, obs_we;
  logic [31:0]      obs_prdata, obs_wdata;
  logic [FB_AW-1:0] obs_addr;
  logic [3:0]       obs_strb;

  vga_fb_wbuf_if #(.FB_AW(FB_AW)) bus ();

  vga_fb_wbuf #(.DEPTH(DEPTH), .FB_AW(FB_AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit drain_ok();
`ifdef VGA_WBUF_BLANK_ONLY_EN
    return bus.vga_blank;
`else
    return 1'b1;
`endif
  endfunction

  // One clock: observe at negedge, compare against the model, then advance the model.
  task automatic step();
    bit   exp_we, exp_push, exp_pop;
    exp_t e;
    if (rand_ready) bus.fb_ready = 1'($urandom_range(0, 1));
    @(negedge clock);
    obs_pready  = bus.in_pready;
    obs_pslverr = bus.in_pslverr;
    obs_prdata  = bus.in_prdata;
    obs_we      = bus.fb_we;
    obs_addr    = bus.fb_addr;
    obs_wdata   = bus.fb_wdata;
    obs_strb    = bus.fb_wstrb;
    exp_we = (q.size() > 0) && drain_ok();
    chk("pready", obs_pready,
        bus.in_psel && bus.in_penable && (!bus.in_pwrite || q.size() < DEPTH));
    chk("pslverr", obs_pslverr, bus.in_psel && bus.in_penable && !bus.in_pwrite);
    chk("prdata", obs_prdata, 32'h0);
    chk("fb_we", obs_we, exp_we);
    if (exp_we) begin
      chk("fb_addr", obs_addr, q[0].addr);
      chk("fb_wdata", obs_wdata, q[0].data);
      chk("fb_wstrb", obs_strb, q[0].strb);
    end
    if (obs_we && bus.fb_ready) dut_log.push_back(obs_wdata);
    exp_push = bus.in_psel && bus.in_penable && bus.in_pwrite && (q.size() < DEPTH);
    exp_pop  = exp_we && bus.fb_ready;
    e.addr = FB_AW'(bus.in_paddr / 4);
    e.data = bus.in_pwdata;
    e.strb = bus.in_pstrb;
    @(posedge clock);
    if (exp_pop) void'(q.pop_front());
    if (exp_push) q.push_back(e);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit done = 1'b0;
    bus.in_psel = 1'b1; bus.in_penable = 1'b0; bus.in_pwrite = 1'b1;
    bus.in_paddr = addr; bus.in_pwdata = data; bus.in_pstrb = strb;
    bus.in_pprot = 3'($urandom_range(0, 7));
    step();
    bus.in_penable = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      step();
      if (obs_pready) done = 1'b1;
    end
    chk("apb_write_done", done, 1'b1);
    bus.in_psel = 1'b0; bus.in_penable = 1'b0; bus.in_pwrite = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.fb_ready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    bus.in_paddr = 32'h0; bus.in_psel = 1'b0; bus.in_penable = 1'b0;
    bus.in_pprot = 3'h0; bus.in_pwrite = 1'b0; bus.in_pwdata = 32'h0;
    bus.in_pstrb = 4'h0; bus.fb_ready = 1'b0; bus.vga_blank = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_fb_we", bus.fb_we, 1'b0);
    chk("rst_pready", bus.in_pready, 1'b0);
    chk("rst_prdata", bus.in_prdata, 32'h0);
    chk("rst_pslverr", bus.in_pslverr, 1'b0);
    reset = 1'b0;
    step();

    // Single write
    bus.fb_ready = 1'b1;
    apb_write(32'h0000_0010, 32'h00FF_8040, 4'hF);
    chk("single_pready", obs_pready, 1'b1);
    chk("single_we_access", obs_we, 1'b0);
    step();
    chk("single_we", obs_we, 1'b1);
    chk("single_addr", obs_addr, 21'd4);
    chk("single_data", obs_wdata, 32'h00FF_8040);
    step();
    chk("single_we_after", obs_we, 1'b0);

    // Fill: 8 writes complete, 9th waits until one pop frees a slot
    bus.fb_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) apb_write(32'h100 + 32'(i * 4), 32'hA000 + 32'(i), 4'hF);
    bus.in_psel = 1'b1; bus.in_penable = 1'b0; bus.in_pwrite = 1'b1;
    bus.in_paddr = 32'h200; bus.in_pwdata = 32'hA008; bus.in_pstrb = 4'h3;
    step();
    bus.in_penable = 1'b1;
    repeat (3) begin
      step();
      chk("fill_hold", obs_pready, 1'b0);
    end
    bus.fb_ready = 1'b1;
    step();
    chk("fill_pop_cycle_hold", obs_pready, 1'b0);
    chk("fill_pop_head", obs_wdata, 32'hA000);
    bus.fb_ready = 1'b0;
    step();
    chk("fill_complete", obs_pready, 1'b1);
    bus.in_psel = 1'b0; bus.in_penable = 1'b0; bus.in_pwrite = 1'b0;
    drain(12);
    chk("fill_drained", obs_we, 1'b0);

    // Ordering with random back-pressure
    dut_log.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) apb_write($urandom & 32'hFFFF_FFFC, 32'(i), 4'($urandom_range(0, 15)));
    rand_ready = 1'b0;
    drain(14);
    chk("order_count", dut_log.size(), 20);
    for (int i = 0; i < 20; i++) begin
      if (i < dut_log.size()) chk("order_data", dut_log[i], 32'(i));
    end

    // Read is rejected and leaves the FIFO alone
    bus.fb_ready = 1'b0;
    apb_write(32'h40, 32'hBEEF_0001, 4'hF);
    apb_write(32'h44, 32'hBEEF_0002, 4'hF);
    bus.in_psel = 1'b1; bus.in_penable = 1'b0; bus.in_pwrite = 1'b0; bus.in_paddr = 32'h0;
    step();
    bus.in_penable = 1'b1;
    step();
    chk("read_pready", obs_pready, 1'b1);
    chk("read_prdata", obs_prdata, 32'h0);
    chk("read_pslverr", obs_pslverr, 1'b1);
    bus.in_psel = 1'b0; bus.in_penable = 1'b0;
    step();
    chk("read_head", obs_wdata, 32'hBEEF_0001);
    chk("read_occupancy", q.size(), 2);
    drain(4);

    // Asynchronous reset with 5 entries queued
    bus.fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) apb_write(32'h300 + 32'(i * 4), 32'hC000 + 32'(i), 4'hF);
    @(posedge clock);
    #2;
    chk("rst_mid_pre_we", bus.fb_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_we", bus.fb_we, 1'b0);
    chk("rst_mid_pready", bus.in_pready, 1'b0);
    q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    bus.fb_ready = 1'b1;
    repeat (4) begin
      step();
      chk("rst_no_stale", obs_we, 1'b0);
    end

    // Drain gating by vga_blank
    bus.vga_blank = 1'b0;
`ifdef VGA_WBUF_BLANK_ONLY_EN
    bus.fb_ready = 1'b1;
    for (int i = 0; i < 3; i++) apb_write(32'h400 + 32'(i * 4), 32'hD000 + 32'(i), 4'hF);
    step();
    chk("blank_hold_we", obs_we, 1'b0);
    bus.vga_blank = 1'b1;
`else
    bus.fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) apb_write(32'h400 + 32'(i * 4), 32'hD000 + 32'(i), 4'hF);
    step();
    chk("blank_ignored_we", obs_we, 1'b1);
    bus.fb_ready = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk("blank_drain_we", obs_we, 1'b1);
      chk("blank_drain_data", obs_wdata, 32'hD000 + 32'(i));
    end
    step();
    chk("blank_drained", obs_we, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_fb_wbuf.md
VGA_FB_WBUF -- requirements
Module: vga_fb_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning write-FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter FB_AW, default 21, meaning frame-buffer word-address width.
REQ-003 SHALL have port clock  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have APB slave ports in_paddr[31:0], in_psel, in_penable, in_pprot[2:0], in_pwrite, in_pwdata[31:0], in_pstrb[3:0] (inputs) and in_pready, in_prdata[31:0], in_pslverr (outputs).
REQ-006 SHALL have port fb_we  output  1  head entry valid toward frame buffer.
REQ-007 SHALL have ports fb_addr output FB_AW, fb_wdata output 32, fb_wstrb output 4: head entry word address, data and byte strobes.
REQ-008 SHALL have port fb_ready  input  1  frame buffer accepts the head entry this cycle.
REQ-009 SHALL have port vga_blank  input  1  display is outside the active region.

Function
REQ-010 SHALL post APB writes into a FIFO so the CPU does not stall on frame-buffer contention.
REQ-011 SHALL treat psel&!penable as the setup phase and psel&penable as the access phase; in_pprot is ignored.
REQ-012 SHALL drive in_pready combinationally = psel & penable & (!pwrite | !full).
REQ-013 SHALL push {in_paddr[FB_AW+1:2], in_pwdata, in_pstrb} exactly once, in the access-phase cycle where in_pready=1 and in_pwrite=1.
REQ-014 SHALL insert wait states (in_pready=0) while the FIFO is full; the write completes in the first cycle it is not full.
REQ-015 SHALL block a push when full even if a pop occurs in the same cycle (no full-pass-through).
REQ-016 SHALL complete reads with in_prdata=0 and in_pslverr=1 in the access phase; writes have in_pslverr=0.
REQ-017 SHALL drive fb_we=1 whenever the FIFO is non-empty (subject to REQ-024), with fb_addr/fb_wdata/fb_wstrb showing the head entry.
REQ-018 SHALL pop the head when fb_we & fb_ready; fb_* outputs stay stable while fb_we=1 and fb_ready=0.
REQ-019 SHALL allow push and pop in the same cycle when neither full nor empty; occupancy is then unchanged.
REQ-020 SHALL add a one-cycle minimum latency: an entry pushed in cycle N appears on fb_we in cycle N+1.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits, full at DEPTH, empty at 0.
REQ-022 SHALL preserve write order; entries are never merged or dropped.

Reset
REQ-023 SHALL, on reset assertion at any time (including mid-transfer), immediately empty the FIFO, clear pointers and counter, and drive fb_we=0, in_pready=0 (when psel low), in_prdata=0, in_pslverr=0; buffered writes are discarded.

Configuration
REQ-024 SHALL, when macro VGA_WBUF_BLANK_ONLY_EN is defined, gate fb_we with vga_blank so entries drain only during blanking; without it, vga_blank is ignored and drain is gated only by occupancy.

Structure
REQ-025 SHALL place APB response constants, DEPTH/FB_AW defaults and the FIFO entry struct typedef (addr, data, strb) in shared package vga_pkg.
REQ-026 SHALL implement storage as sub-module vga_wbuf_fifo (synchronous FIFO, push/pop/full/empty/head).

Verification
REQ-027 SHALL test single write: addr 0x0000_0010, data 0x00FF_8040, strb 0xF, fb_ready=1 -> in_pready in access cycle; next cycle fb_we=1, fb_addr=4, fb_wdata=0x00FF_8040; fb_we=0 after.
REQ-028 SHALL test fill: fb_ready=0, 9 back-to-back writes with DEPTH=8 -> 8 complete, 9th holds in_pready=0; fb_ready=1 for one cycle -> 9th completes the following cycle.
REQ-029 SHALL test ordering: 20 writes of data=i with random fb_ready -> fb_wdata sequence 0..19, pointer wrap covered, none lost.
REQ-030 SHALL test read: APB read at 0x0 -> in_pready=1, in_prdata=0, in_pslverr=1, FIFO unchanged.
REQ-031 SHALL test reset mid-operation: 5 entries queued, reset asserted asynchronously -> fb_we=0 immediately; after release, no stale entry is emitted.
REQ-032 SHALL test with VGA_WBUF_BLANK_ONLY_EN: vga_blank=0 with 3 queued -> fb_we=0; vga_blank=1, fb_ready=1 -> 3 pops in 3 cycles.
